// File: rtl/s_prior_dec_hold.sv
// s_prior_dec_hold: turns a priority index back into a one-hot grant vector.
// Bit ordering follows the 12-input priority encoder: index 0 drives
// onehot_out[0], which is the leftmost and highest-priority position.
// Each decoded vector is held for HOLD cycles behind a valid/ready
// handshake. Out-of-range indices produce a single-cycle err pulse.
//
// state  | meaning
// IDLE   | no vector on the output, ready to accept
// HOLD   | vector on the output, counter counts down to the last hold cycle
module s_prior_dec_hold #(
  parameter int N    = 12,
  parameter int W    = 4,
  parameter int HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:W-1] code_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:N-1] onehot_out,
  output logic         out_valid,
  output logic         busy,
  output logic         err
);

  // A 1-bit counter is kept even when HOLD=1, so the compare logic has a
  // single form for every HOLD value.
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);
  localparam logic [W:0]    N_LIM  = (W + 1)'(N);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [0:N-1]  r_onehot;
  logic          r_valid;
  logic          r_busy;
  logic          r_err;

  logic [0:N-1]  w_dec;
  logic          w_code_ok;
  logic          w_ready;
  logic          w_accept;

  // Ready depends only on registered state, never on in_valid. The last
  // hold cycle accepts so back-to-back codes follow with no gap.
  always_comb begin
    w_ready = (r_state == S_IDLE) || (r_cnt == '0);
  end

  // Decode the index and classify it as in or out of range.
  always_comb begin
    w_dec     = '0;
    w_code_ok = ({1'b0, code_in} < N_LIM);
    for (int i = 0; i < N; i++) begin
      if (code_in == W'(i)) begin
        w_dec[i] = 1'b1;
      end
    end
    w_accept = in_valid && w_ready;
  end

  // Handshake FSM with registered outputs and hold down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (w_code_ok) begin
          r_state  <= S_HOLD;
          r_cnt    <= RELOAD;
          r_onehot <= w_dec;
          r_valid  <= 1'b1;
          r_busy   <= 1'b1;
        end else begin
          // Bad index: drop any vector and return to IDLE with an err pulse.
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_onehot <= '0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_err    <= 1'b1;
        end
      end else if (r_state == S_HOLD) begin
        if (r_cnt == '0) begin
          r_state  <= S_IDLE;
          r_onehot <= '0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign in_ready   = w_ready;
  assign onehot_out = r_onehot;
  assign out_valid  = r_valid;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: doc/s_prior_dec_hold.md
Name: s_prior_dec_hold

Overview:
- Return-direction partner of the 12-input priority encoder: accepts a 4-bit priority index and regenerates the 12-bit one-hot vector.
- Uses the same bit ordering as the encoder. Index 0 drives vector bit [0], the highest-priority position. Index 11 drives bit [11].
- Each decoded vector is registered and held for a programmable number of cycles behind a valid/ready handshake.
- Out-of-range indices (12..15) are flagged with an error pulse.
- Sits downstream of the encoder on the grant/select path.

Parameters:
- N, 12, number of one-hot lines. Legal index range is 0..N-1.
- W, 4, index width in bits. Must satisfy 2^W >= N.
- HOLD, 4, number of cycles each decoded vector stays on the output. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- code_in  input  [0:W-1]  priority index; code_in[0] is the MSB.
- in_valid  input  1  code_in is valid this cycle.
- in_ready  output  1  block will accept code_in at this rising edge.
- onehot_out  output  [0:N-1]  decoded vector; at most one bit set.
- out_valid  output  1  onehot_out holds a live decoded vector.
- busy  output  1  high while in the HOLD state.
- err  output  1  one-cycle pulse: an out-of-range index was accepted.

Behaviour:
- Accept event: rising edge with in_valid=1 and in_ready=1.
- Reset: rst is sampled only at the clock edge.
  - Reset values: state=IDLE, onehot_out=0, out_valid=0, busy=0, err=0, hold counter=0.
  - rst has priority over every other event, including an accept in the same cycle.
  - Asserting rst mid-hold clears the output on the next edge.
- FSM states are IDLE and HOLD.
- in_ready (combinational from registered state only, never from in_valid):
  - 1 in IDLE.
  - 1 in HOLD when the counter equals 0 (last hold cycle).
  - 0 otherwise.
  - With HOLD=1, in_ready is always 1 outside reset.
- Valid accept (code_in < N):
  - On the accept edge: onehot_out[code_in]=1 and all other bits 0, out_valid=1, busy=1, counter=HOLD-1, state=HOLD.
  - Latency from accept edge to output is 0 extra cycles; the output is visible in the cycle after the edge.
- Invalid accept (code_in >= N):
  - On the accept edge: err=1 for exactly one cycle, onehot_out=0, out_valid=0, busy=0, state=IDLE.
  - No decoded vector is produced.
- HOLD state:
  - Counter decrements by 1 per cycle.
  - On the edge where counter==0 and no accept occurs: state=IDLE, onehot_out=0, out_valid=0, busy=0.
  - Result: out_valid is high for exactly HOLD consecutive cycles per valid accept.
- Back-to-back accepts in the last hold cycle:
  - Valid code: reload the vector and counter with no gap; out_valid stays 1.
  - Invalid code: drop to IDLE and pulse err.
- in_valid while in_ready=0: ignored. No buffering; the upstream stage must hold code_in.
- err is cleared on every edge that is not an invalid accept.
- Counter is ceil(log2(HOLD)) bits wide, minimum 1. It never wraps below 0.
- Invariant: onehot_out is always zero or exactly one-hot, and is non-zero exactly when out_valid=1.

Test Plan:
- Reset with rst=1 for 2 cycles, then release → all outputs 0 and in_ready=1 on the first cycle after release.
- code_in=4'b0000 accepted with HOLD=4 → onehot_out=12'b1000_0000_0000 and out_valid=1 for exactly 4 cycles; in_ready=0 for the first 3 of those cycles; then outputs return to 0.
- code_in=4'b1011 accepted, then code_in=4'b0101 presented with in_valid held high → first vector 12'b0000_0000_0001 for 4 cycles, then 12'b0000_0100_0000 for 4 cycles with no out_valid gap.
- code_in=4'b1100 and then 4'b1111 accepted from IDLE → err=1 for one cycle each, onehot_out=0, out_valid=0, state stays IDLE.
- code_in=4'b0011 accepted, then rst=1 on the second hold cycle → next cycle onehot_out=0, out_valid=0, busy=0, in_ready=1 after release.
- Sweep all 16 codes with HOLD=1 and in_valid continuously high → codes 0..11 give single-cycle one-hot vectors matching the encoder mapping (the encoder applied to the output returns the same code); codes 12..15 give err pulses.
